// File: rtl/cellrv32_cpu_cp_dispatch_if.sv
// Co-processor array bus: per-slot implemented flags, start pulses, result valids and results.
// No storage and no latency of its own; the array returns each result one cycle after its valid.
// No backpressure: a slot answers a start with a valid whenever it is ready.
interface cellrv32_cpu_cp_dispatch_if #(
    parameter int NUM_CP = 8,
    parameter int XLEN   = 32
);
    logic [NUM_CP-1:0]      cp_en;
    logic [NUM_CP-1:0]      cp_start;
    logic [NUM_CP-1:0]      cp_valid;
    logic [NUM_CP*XLEN-1:0] cp_res;

    // master: the CPU-side dispatcher; slave: the co-processor array
    modport master (
        input  cp_en,
        input  cp_valid,
        input  cp_res,
        output cp_start
    );

    modport slave (
        output cp_en,
        output cp_valid,
        output cp_res,
        input  cp_start
    );
endinterface

// File: rtl/cellrv32_cpu_cp_dispatch.sv
// Co-processor dispatcher: one-hot start pulse, wait for the slot's valid, capture its result, pulse done/exc.
// Latency: request to done is 3 cycles minimum, N+3 when valid comes N cycles after start; unimplemented slot 1 cycle.
// Backpressure: requests are taken only while idle and never queued; CELLRV32_CP_TIMEOUT_EN adds a BUSY timeout.
module cellrv32_cpu_cp_dispatch #(
    parameter int XLEN     = 32,
    parameter int NUM_CP   = 8,
    parameter int TMO_BITS = 7,
    localparam int IDXW    = $clog2(NUM_CP)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                req_i,
    input  logic [IDXW-1:0]                     sel_i,
    input  logic                                abort_i,
    cellrv32_cpu_cp_dispatch_if.master          cp,
    output logic [XLEN-1:0]                     res_o,
    output logic                                done_o,
    output logic                                exc_o,
    output logic                                busy_o
);

    if (NUM_CP < 2 || TMO_BITS < 2) begin : g_param_chk
        $error("cellrv32_cpu_cp_dispatch: NUM_CP and TMO_BITS must both be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        CAPT  = 2'd3
    } state_t;

    state_t            state_q, state_nxt;
    logic [IDXW-1:0]   idx_q;
    logic              sel_in_range;
    logic              slot_ok;
    logic              accept;
    logic              valid_sel;
    logic [XLEN-1:0]   res_sel;
    logic              tmo_hit;

    logic [NUM_CP-1:0] start_q, start_nxt;
    logic [XLEN-1:0]   res_nxt;
    logic              done_nxt, exc_nxt;

    // Indices past the last slot only exist when NUM_CP is not a power of two.
    if ((1 << IDXW) == NUM_CP) begin : g_sel_full
        assign sel_in_range = 1'b1;
    end else begin : g_sel_part
        assign sel_in_range = ({1'b0, sel_i} < (IDXW+1)'(NUM_CP));
    end

    always_comb begin
        slot_ok = 1'b0;
        if (sel_in_range) begin
            slot_ok = cp.cp_en[sel_i];
        end
    end

    assign accept    = (state_q == IDLE) && req_i && slot_ok && !abort_i;
    assign valid_sel = cp.cp_valid[idx_q];
    assign res_sel   = cp.cp_res[idx_q*XLEN +: XLEN];

`ifdef CELLRV32_CP_TIMEOUT_EN
    localparam logic [TMO_BITS-1:0] TMO_LAST = TMO_BITS'((2 ** TMO_BITS) - 2);

    logic [TMO_BITS-1:0] tmo_cnt_q;

    // Counts silent BUSY cycles; the one that would reach the all-ones value is the last one allowed.
    always_ff @(posedge clk_i) begin
        if (rst_i || state_q != BUSY) begin
            tmo_cnt_q <= '0;
        end else if (!valid_sel) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    assign tmo_hit = (tmo_cnt_q == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_nxt;
            if (accept) begin
                idx_q <= sel_i;
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        if (abort_i) begin
            state_nxt = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (req_i && slot_ok) state_nxt = START;
                START:   state_nxt = valid_sel ? CAPT : BUSY;
                BUSY: begin
                    if (valid_sel) begin
                        state_nxt = CAPT;
                    end else if (tmo_hit) begin
                        state_nxt = IDLE;
                    end
                end
                CAPT:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs; abort swallows every pulse and leaves res_o alone.
    always_comb begin
        start_nxt = '0;
        done_nxt  = 1'b0;
        exc_nxt   = 1'b0;
        res_nxt   = res_o;
        if (!abort_i) begin
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        if (slot_ok) begin
                            start_nxt[sel_i] = 1'b1;
                        end else begin
                            done_nxt = 1'b1;
                            exc_nxt  = 1'b1;
                            res_nxt  = '0;
                        end
                    end
                end
                BUSY: begin
                    if (!valid_sel && tmo_hit) begin
                        done_nxt = 1'b1;
                        exc_nxt  = 1'b1;
                        res_nxt  = '0;
                    end
                end
                CAPT: begin
                    done_nxt = 1'b1;
                    res_nxt  = res_sel;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            start_q <= '0;
            done_o  <= 1'b0;
            exc_o   <= 1'b0;
            res_o   <= '0;
        end else begin
            start_q <= start_nxt;
            done_o  <= done_nxt;
            exc_o   <= exc_nxt;
            res_o   <= res_nxt;
        end
    end

    // The start register is set on entry to START; a flush raised during that cycle still kills the pulse.
    assign cp.cp_start = start_q & {NUM_CP{~abort_i}};
    assign busy_o      = (state_q != IDLE);

endmodule
